// File: rtl/demux_buffered_pkg.sv
// demux_buffered: shared constants and helpers.
// Width helper mirroring the usual safe clog2 (never returns 0).
package demux_buffered_pkg;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/demux_buffered_fifo.sv
// demux_buffered_fifo: per-lane circular FIFO with occupancy count.
// Storage is cleared on reset so an idle lane reads zero.
module demux_buffered_fifo
    import demux_buffered_pkg::*;
#(
    parameter int data_width_p = 8,
    parameter int els_p = 2,
    localparam int ptr_width_lp = safe_clog2(els_p),
    localparam int cnt_width_lp = safe_clog2(els_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    enq_i,
    input  logic [data_width_p-1:0] data_i,
    input  logic                    deq_i,
    output logic [data_width_p-1:0] data_o,
    output logic                    v_o,
    output logic                    full_o,
    output logic [cnt_width_lp-1:0] count_o
);

    logic [data_width_p-1:0] mem [els_p];
    logic [ptr_width_lp-1:0] rd_ptr;
    logic [ptr_width_lp-1:0] wr_ptr;
    logic                    enq_ok;
    logic                    deq_ok;

    assign full_o = (count_o == cnt_width_lp'(els_p));
    assign v_o    = (count_o != '0);
    assign enq_ok = enq_i & ~full_o;
    assign deq_ok = deq_i & v_o;
    assign data_o = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_o <= '0;
            for (int k = 0; k < els_p; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (enq_ok) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + ptr_width_lp'(1);
            end
            if (deq_ok) begin
                rd_ptr <= rd_ptr + ptr_width_lp'(1);
            end
            count_o <= count_o + cnt_width_lp'(enq_ok)
                               - cnt_width_lp'(deq_ok);
        end
    end

    // A dequeue on an empty lane is dropped in hardware but flagged here
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(deq_i && !v_o))
            else $error("dequeue on empty lane");
        end
    end

endmodule

// File: rtl/demux_buffered.sv
// demux_buffered: unicast/broadcast demux into per-lane FIFOs.
// Broadcast is all-or-nothing; bad unicast selects drop with err_o.
module demux_buffered
    import demux_buffered_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int num_outputs_p = 4,
    parameter int els_p = 2,
    localparam int sel_width_lp = safe_clog2(num_outputs_p),
    localparam int cnt_width_lp = safe_clog2(els_p + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  v_i,
    input  logic [data_width_p-1:0]               data_i,
    input  logic                                  bcast_i,
    input  logic [sel_width_lp-1:0]               sel_i,
    input  logic [num_outputs_p-1:0]              mask_i,
    output logic                                  ready_o,
    output logic [num_outputs_p-1:0]              v_o,
    output logic [num_outputs_p*data_width_p-1:0] data_o,
    input  logic [num_outputs_p-1:0]              yumi_i,
    output logic [num_outputs_p*cnt_width_lp-1:0] count_o,
    output logic                                  err_o
);

    logic [num_outputs_p-1:0] tgt;
    logic [num_outputs_p-1:0] full;
    logic                     bad_sel;
    logic                     acc;

    always_comb begin
        tgt     = '0;
        bad_sel = 1'b0;
        if (bcast_i) begin
            tgt = mask_i;
        end else if ({1'b0, sel_i} < (sel_width_lp + 1)'(num_outputs_p)) begin
            tgt = num_outputs_p'(1) << sel_i;
        end else begin
            bad_sel = 1'b1;
        end
    end

    // Full is start-of-cycle state: a same-cycle yumi does not free a slot
    assign ready_o = &(~tgt | ~full);
    assign acc     = v_i & ready_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_o <= 1'b0;
        end else begin
            err_o <= acc & bad_sel;
        end
    end

    for (genvar i = 0; i < num_outputs_p; i++) begin : g_lane
        demux_buffered_fifo #(
            .data_width_p(data_width_p),
            .els_p       (els_p)
        ) u_fifo (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .enq_i    (acc & tgt[i]),
            .data_i   (data_i),
            .deq_i    (yumi_i[i]),
            .data_o   (data_o[i*data_width_p +: data_width_p]),
            .v_o      (v_o[i]),
            .full_o   (full[i]),
            .count_o  (count_o[i*cnt_width_lp +: cnt_width_lp])
        );
    end

endmodule
